pipe_hazard_ctrl: RTL

//  Parametrised pipeline hazard/control unit for the RV32I core.
//  - Replaces the fixed single-source forwarding and stall/flush logic.
//  - Forwards from NFWD downstream stages and inserts load-use stalls.
//  - Sequences branch/mret redirects and flushes.
//  - Drains the pipe on an interrupt before redirecting to the trap vector.
//  - Sits beside the DE stage; drives PC-select, IF stall and DE flush.

---
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RV32I pipeline hazard/control unit: forwarding, load-use stalls, redirects, interrupt drain
module pipe_hazard_ctrl #(
  parameter int NFWD         = 2,
  parameter int LU_STALL_CYC = 1,
  parameter int BR_FLUSH_CYC = 1,
  localparam int SW          = $clog2(NFWD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_if,
  input  logic [4:0]        rs2_if,
  input  logic              use_rs1_if,
  input  logic              use_rs2_if,
  input  logic [4:0]        rs1_de,
  input  logic [4:0]        rs2_de,
  input  logic [4:0]        rd_de,
  input  logic              rf_en_de,
  input  logic              is_load_de,
  input  logic [5*NFWD-1:0] rd_fw,
  input  logic [NFWD-1:0]   rf_en_fw,
  input  logic              br_taken_de,
  input  logic              mret_de,
  input  logic              irq_req,
  output logic [SW-1:0]     fwd_sel_a,
  output logic [SW-1:0]     fwd_sel_b,
  output logic              stall_if,
  output logic              flush_de,
  output logic              redir_vld,
  output logic [1:0]        redir_sel,
  output logic              epc_we,
  output logic              irq_ack
);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_LU    = 3'd1,
    S_FL    = 3'd2,
    S_DRAIN = 3'd3,
    S_TRAP  = 3'd4
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_TRAP = 2'd1;
  localparam logic [1:0] SEL_EPC  = 2'd2;

  // Counter preloads; a sequence of length 1 never leaves RUN, so the
  // clamped value is unused in that case.
  localparam logic [2:0] LU_LOAD    = 3'(LU_STALL_CYC > 1 ? LU_STALL_CYC - 2 : 0);
  localparam logic [2:0] FL_LOAD    = 3'(BR_FLUSH_CYC > 1 ? BR_FLUSH_CYC - 2 : 0);
  localparam logic [2:0] DRAIN_LOAD = 3'(NFWD - 1);

  state_t     state;
  logic [2:0] cnt;

  logic       redirect;
  logic       load_use;
  logic       rd_de_nz;
  logic       rs1_hit;
  logic       rs2_hit;
  logic [SW-1:0] sel_a_raw;
  logic [SW-1:0] sel_b_raw;

  // Redirect request and load-use detection against the instruction in IF.
  always_comb begin
    redirect = br_taken_de | mret_de;
    rd_de_nz = (rd_de != 5'd0);
    rs1_hit  = use_rs1_if & (rs1_if == rd_de);
    rs2_hit  = use_rs2_if & (rs2_if == rd_de);
    load_use = is_load_de & rf_en_de & rd_de_nz & (rs1_hit | rs2_hit);
  end

  // Forward select: scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    sel_a_raw = '0;
    sel_b_raw = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (rf_en_fw[k] && (rs1_de != 5'd0) && (rd_fw[5*k +: 5] == rs1_de)) begin
        sel_a_raw = SW'(k + 1);
      end
      if (rf_en_fw[k] && (rs2_de != 5'd0) && (rd_fw[5*k +: 5] == rs2_de)) begin
        sel_b_raw = SW'(k + 1);
      end
    end
  end

  // Control sequencer: RUN arbitrates irq > redirect > load-use, others count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= 3'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (irq_req) begin
            state <= S_DRAIN;
            cnt   <= DRAIN_LOAD;
          end else if (redirect) begin
            if (BR_FLUSH_CYC > 1) begin
              state <= S_FL;
              cnt   <= FL_LOAD;
            end
          end else if (load_use) begin
            if (LU_STALL_CYC > 1) begin
              state <= S_LU;
              cnt   <= LU_LOAD;
            end
          end
        end
        S_LU, S_FL: begin
          if (cnt == 3'd0) begin
            state <= S_RUN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DRAIN: begin
          if (cnt == 3'd0) begin
            state <= S_TRAP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_TRAP: begin
          state <= S_RUN;
          cnt   <= 3'd0;
        end
        default: begin
          state <= S_RUN;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Output decode from the current state and, in RUN, the same-cycle requests.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    stall_if  = 1'b0;
    flush_de  = 1'b0;
    redir_vld = 1'b0;
    redir_sel = SEL_ALU;
    epc_we    = 1'b0;
    irq_ack   = 1'b0;
    if (!rst) begin
      fwd_sel_a = sel_a_raw;
      fwd_sel_b = sel_b_raw;
      case (state)
        S_RUN: begin
          if (redirect) begin
            redir_vld = 1'b1;
            redir_sel = mret_de ? SEL_EPC : SEL_ALU;
            flush_de  = 1'b1;
          end
          if (irq_req) begin
            stall_if = 1'b1;
            flush_de = 1'b1;
          end else if (!redirect && load_use) begin
            stall_if = 1'b1;
            flush_de = 1'b1;
          end
        end
        S_LU, S_DRAIN: begin
          stall_if = 1'b1;
          flush_de = 1'b1;
        end
        S_FL: begin
          flush_de = 1'b1;
        end
        S_TRAP: begin
          redir_vld = 1'b1;
          redir_sel = SEL_TRAP;
          epc_we    = 1'b1;
          irq_ack   = 1'b1;
          flush_de  = 1'b1;
        end
        default: begin
          flush_de = 1'b0;
        end
      endcase
    end
  end

endmodule
